// File: rtl/sram_pkg.sv
// Shared defaults and geometry helpers for the cache data-array RAM.
package sram_pkg;

    localparam int unsigned DEF_WORDSIZE = 64;
    localparam int unsigned DEF_WIDTH    = 512;
    localparam int unsigned DEF_LOGDEPTH = 9;

    // Number of independently writable words in one line.
    function automatic int unsigned words_per_line(input int unsigned width,
                                                   input int unsigned wordsize);
        return width / wordsize;
    endfunction

endpackage

// File: rtl/sram_if.sv
// Read/write port bundle of the cache data-array RAM.
interface sram_if
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned WORDSIZE = DEF_WORDSIZE,
    parameter int unsigned LOGDEPTH = DEF_LOGDEPTH
) ();

    localparam int unsigned NWORDS = words_per_line(WIDTH, WORDSIZE);

    logic [LOGDEPTH-1:0] readAddr;
    logic [WIDTH-1:0]    readData;
    logic [LOGDEPTH-1:0] writeAddr;
    logic [WIDTH-1:0]    writeData;
    logic [NWORDS-1:0]   writeEnable;

    // Cache controller side.
    modport master (
        output readAddr,
        input  readData,
        output writeAddr,
        output writeData,
        output writeEnable
    );

    // RAM side.
    modport slave (
        input  readAddr,
        output readData,
        input  writeAddr,
        input  writeData,
        input  writeEnable
    );

endinterface

// File: rtl/sram_read_pipe.sv
// N-stage register chain between the array read and readData, cleared asynchronously.
module sram_read_pipe #(
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the read data one stage per edge; reset empties every stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // predecessor's pre-edge value, so the chain shifts by exactly one.
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sram.sv
// Cache data array: 2^LOGDEPTH lines of WIDTH bits, per-word write enables,
// independent read port with optional pipelined (read-old) latency.
module sram
    import sram_pkg::*;
#(
    parameter int unsigned WORDSIZE     = DEF_WORDSIZE,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned LOGDEPTH     = DEF_LOGDEPTH,
    parameter int unsigned READ_LATENCY = 0
) (
    input logic   clk,
    input logic   reset_n,
    sram_if.slave bus
);

    localparam int unsigned NWORDS = words_per_line(WIDTH, WORDSIZE);
    localparam int unsigned DEPTH  = 1 << LOGDEPTH;

    if (WIDTH % WORDSIZE != 0) begin : g_width_check
        $error("sram: WIDTH (%0d) must be a multiple of WORDSIZE (%0d)", WIDTH, WORDSIZE);
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_raw;

    // Per-word write of the addressed line; disabled words keep their contents.
    // NOTE: the storage array deliberately has no reset: clearing it would
    // defeat block-RAM inference, and cache contents are validated by tags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NWORDS); i++) begin
            if (bus.writeEnable[i]) begin
                mem[bus.writeAddr][i*WORDSIZE +: WORDSIZE] <= bus.writeData[i*WORDSIZE +: WORDSIZE];
            end
        end
    end

    // Array read is asynchronous; an edge-sampled copy of it sees the pre-write line.
    assign rd_raw = mem[bus.readAddr];

    if (READ_LATENCY == 0) begin : g_comb_read
        assign bus.readData = rd_raw;
    end else begin : g_pipe_read
        sram_read_pipe #(
            .WIDTH  (WIDTH),
            .STAGES (READ_LATENCY)
        ) u_read_pipe (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (rd_raw),
            .q       (bus.readData)
        );
    end

endmodule

// File: tb/tb_sram.sv
// Self-checking bench: three RAMs (latency 0, 1, 2) share one stimulus stream
// and are compared every cycle against a line-array model with a read history.
module tb_sram;
    import sram_pkg::*;

    localparam int WS    = 64;
    localparam int W     = 512;
    localparam int LD    = 9;
    localparam int NW    = W / WS;
    localparam int DEPTH = 1 << LD;

    typedef logic [W-1:0] line_t;
    typedef struct {
        line_t val;
        bit    known;
    } samp_t;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [LD-1:0] read_addr  = '0;
    logic [LD-1:0] write_addr = '0;
    line_t         write_data = '0;
    logic [NW-1:0] write_en   = '0;

    line_t rd0, rd1, rd2;

    int checks = 0;
    int errors = 0;

    // Reference model: line contents, which lines are fully known, and the
    // values sampled at the most recent edges (newest first).
    line_t mem_m   [DEPTH];
    bit    valid_m [DEPTH];
    samp_t hist_q  [$];

    always #5 clk = ~clk;

    sram_if #(.WIDTH(W), .WORDSIZE(WS), .LOGDEPTH(LD)) if0 ();
    sram_if #(.WIDTH(W), .WORDSIZE(WS), .LOGDEPTH(LD)) if1 ();
    sram_if #(.WIDTH(W), .WORDSIZE(WS), .LOGDEPTH(LD)) if2 ();

    assign if0.readAddr = read_addr;  assign if0.writeAddr = write_addr;
    assign if0.writeData = write_data; assign if0.writeEnable = write_en;
    assign if1.readAddr = read_addr;  assign if1.writeAddr = write_addr;
    assign if1.writeData = write_data; assign if1.writeEnable = write_en;
    assign if2.readAddr = read_addr;  assign if2.writeAddr = write_addr;
    assign if2.writeData = write_data; assign if2.writeEnable = write_en;
    assign rd0 = if0.readData;
    assign rd1 = if1.readData;
    assign rd2 = if2.readData;

    sram #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD), .READ_LATENCY(0))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    sram #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD), .READ_LATENCY(1))
        u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
    sram #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD), .READ_LATENCY(2))
        u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

    task automatic check(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Value a latency-n port must show: the line sampled n edges ago, or 0
    // if the pipeline has not been loaded that far since reset.
    function automatic samp_t expect_pipe(input int n);
        samp_t z;
        z.val   = '0;
        z.known = 1'b1;
        if (n - 1 < hist_q.size()) return hist_q[n-1];
        return z;
    endfunction

    // Model update at each edge: sample the read line before applying the write.
    always @(posedge clk or negedge reset_n) begin : model
        samp_t s;
        if (!reset_n) begin
            hist_q.delete();
        end else begin
            s.val   = mem_m[read_addr];
            s.known = valid_m[read_addr];
            hist_q.push_front(s);
            if (hist_q.size() > 2) void'(hist_q.pop_back());
            for (int i = 0; i < NW; i++) begin
                if (write_en[i]) mem_m[write_addr][i*WS +: WS] = write_data[i*WS +: WS];
            end
            if (write_en == '1) valid_m[write_addr] = 1'b1;
        end
    end

    // Per-cycle comparison of all three read ports against the model.
    always @(negedge clk) begin : compare
        samp_t e1, e2;
        if (valid_m[read_addr]) check("rd_lat0", rd0, mem_m[read_addr]);
        if (!reset_n) begin
            check("rd_lat1_in_reset", rd1, '0);
            check("rd_lat2_in_reset", rd2, '0);
        end else begin
            e1 = expect_pipe(1);
            e2 = expect_pipe(2);
            if (e1.known) check("rd_lat1", rd1, e1.val);
            if (e2.known) check("rd_lat2", rd2, e2.val);
        end
    end

    task automatic drive(input logic [LD-1:0] ra, input logic [LD-1:0] wa,
                         input line_t wd, input logic [NW-1:0] we);
        read_addr  = ra;
        write_addr = wa;
        write_data = wd;
        write_en   = we;
    endtask

    // Advance past one rising edge and land just after the following falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin : stimulus
        line_t a5, beef, p7, exp7, old20, new10, l1, l2, old5;
        int    mode;
        logic [LD-1:0] ra, wa;
        logic [NW-1:0] we;

        a5   = {64{8'hA5}};
        beef = {32{16'hBEEF}};

        // Reset state: pipelined ports read zero while reset is held.
        #2;
        check("reset_lat1", rd1, '0);
        check("reset_lat2", rd2, '0);
        step();
        step();
        reset_n = 1'b1;

        // Fill every line with known data.
        for (int ln = 0; ln < DEPTH; ln++) begin
            drive(LD'($urandom_range(0, DEPTH - 1)), LD'(ln), rand_line(), '1);
            step();
        end

        // Full-line write, visible on the combinational port right after the edge.
        drive('0, 9'd3, a5, 8'hFF);
        step();
        drive(9'd3, '0, '0, '0);
        #1;
        check("full_line_l3", rd0, a5);

        // Partial write: only word 2 changes.
        for (int i = 0; i < NW; i++) p7[i*WS +: WS] = {60'h111111111111111, 4'(i)};
        exp7 = p7;
        exp7[2*WS +: WS] = 64'hFFFF_FFFF_FFFF_FFFF;
        drive('0, 9'd7, p7, 8'hFF);
        step();
        drive(9'd7, 9'd7, '1, 8'b0000_0100);
        #1;
        check("partial_before", rd0, p7);
        step();
        check("partial_word2", rd0, exp7);

        // Independent ports: write line 10 while reading line 20.
        old20 = mem_m[20];
        new10 = rand_line();
        drive(9'd20, 9'd10, new10, 8'hFF);
        #1;
        check("indep_rd20_pre", rd0, old20);
        step();
        check("indep_rd20_post", rd0, old20);
        drive(9'd10, '0, '0, '0);
        #1;
        check("indep_rd10", rd0, new10);

        // Latency 2, fully pipelined: addresses 1, 2, 3 back to back.
        l1 = mem_m[1];
        l2 = mem_m[2];
        drive(9'd1, '0, '0, '0);
        step();
        drive(9'd2, '0, '0, '0);
        step();
        check("lat2_line1", rd2, l1);
        drive(9'd3, '0, '0, '0);
        step();
        check("lat2_line2", rd2, l2);
        step();
        check("lat2_line3", rd2, a5);

        // Same-line collision: latency 1 returns the old line, then the new one.
        old5 = mem_m[5];
        drive(9'd5, 9'd5, beef, 8'hFF);
        step();
        check("collide_old", rd1, old5);
        check("collide_lat0_new", rd0, beef);
        drive(9'd5, '0, '0, '0);
        step();
        check("collide_new", rd1, beef);

        // Asynchronous reset mid-stream; array contents survive.
        drive(9'd3, '0, '0, '0);
        step();
        step();
        check("pre_rst_lat2", rd2, a5);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_lat2_zero", rd2, '0);
        check("rst_lat1_zero", rd1, '0);
        check("rst_lat0_array", rd0, a5);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("rst_refill_first", rd2, '0);
        step();
        check("rst_line3_intact", rd2, a5);

        // Randomized traffic, with same-line collisions mixed in.
        for (int n = 0; n < 3000; n++) begin
            ra   = LD'($urandom_range(0, DEPTH - 1));
            wa   = ($urandom_range(0, 3) == 0) ? ra : LD'($urandom_range(0, DEPTH - 1));
            mode = $urandom_range(0, 3);
            we   = (mode == 0) ? '0 : (mode == 1) ? '1 : NW'($urandom);
            drive(ra, wa, rand_line(), we);
            step();
        end

        drive('0, '0, '0, '0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
